// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared display-buffer types, sizes and pixel packing
package disp_pkg;

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_FILL = 1'b1
   } wr_state_e;

   localparam int FRAME_WORDS_DEF = 307200;
   localparam int ADDR_W_DEF      = 20;

   // RGB field positions inside a buffer word; the read path unpacks with the same constants
   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;

   function automatic logic [31:0] pack_pixel(input logic [23:0] px);
      return {8'h00, px[R_MSB:R_LSB], px[G_MSB:G_LSB], px[B_MSB:B_LSB]};
   endfunction

endpackage

// File: rtl/wr_addr_counter.sv
// rtl/wr_addr_counter.sv - write address counter with clear and terminal-count flag
module wr_addr_counter
   import disp_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc_i,
   input  logic              clr_i,
   output logic [ADDR_W-1:0] cnt_o,
   output logic              tc_o
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + ADDR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == ADDR_W'(FRAME_WORDS - 1));

endmodule

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - fills ping-pong display buffers from a host pixel stream
module frame_buffer_writer
   import disp_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              HostValid,
   input  logic [23:0]       HostData,
   input  logic              HostLast,
   output logic              HostReady,
   input  logic              Buf0Empty,
   input  logic              Buf1Empty,
   output logic [31:0]       WData,
   output logic [ADDR_W-1:0] WAddr,
   output logic              WE0,
   output logic              WE1,
   output logic              Buf0Full,
   output logic              Buf1Full,
   output logic              FrameErr
);

   wr_state_e         state_q, state_d;
   logic              wrsel_q, wrsel_d;
   logic [1:0]        full_q, full_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [1:0]        we_q, we_d;
   logic              ferr_q, ferr_d;
   logic [ADDR_W-1:0] cnt;
   logic              tc;
   logic              hs;
   logic              eof;
   logic [1:0]        sel_mask;

   assign HostReady = (state_q == ST_FILL);
   assign hs        = HostValid && HostReady;
   assign eof       = hs && (tc || HostLast);
   assign sel_mask  = wrsel_q ? 2'b10 : 2'b01;

   wr_addr_counter #(
      .FRAME_WORDS(FRAME_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc_i(hs),
      .clr_i(eof),
      .cnt_o(cnt),
      .tc_o (tc)
   );

   always_comb begin
      state_d = state_q;
      wrsel_d = wrsel_q;
      full_d  = full_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      we_d    = 2'b00;
      ferr_d  = 1'b0;

      if (full_q[0] && Buf0Empty) full_d[0] = 1'b0;
      if (full_q[1] && Buf1Empty) full_d[1] = 1'b0;

      if (hs) begin
         wdata_d = pack_pixel(HostData);
         waddr_d = cnt;
         we_d    = sel_mask;
      end

      // Release of the other buffer and setting this one are independent bits
      if (eof) begin
         full_d  = full_d | sel_mask;
         wrsel_d = ~wrsel_q;
         ferr_d  = (tc != HostLast);
         state_d = ST_WAIT;
      end else if (state_q == ST_WAIT && !full_q[wrsel_q]) begin
         state_d = ST_FILL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT;
         wrsel_q <= 1'b0;
         full_q  <= 2'b00;
         wdata_q <= '0;
         waddr_q <= '0;
         we_q    <= 2'b00;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrsel_q <= wrsel_d;
         full_q  <= full_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
         ferr_q  <= ferr_d;
      end
   end

   assign WData    = wdata_q;
   assign WAddr    = waddr_q;
   assign WE0      = we_q[0];
   assign WE1      = we_q[1];
   assign Buf0Full = full_q[0];
   assign Buf1Full = full_q[1];
   assign FrameErr = ferr_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - directed bench for frame_buffer_writer with 4-word frames
module tb_frame_buffer_writer;

   localparam int FW = 4;
   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          HostValid;
   logic [23:0]   HostData;
   logic          HostLast;
   logic          HostReady;
   logic          Buf0Empty;
   logic          Buf1Empty;
   logic [31:0]   WData;
   logic [AW-1:0] WAddr;
   logic          WE0;
   logic          WE1;
   logic          Buf0Full;
   logic          Buf1Full;
   logic          FrameErr;

   int checks = 0;
   int errors = 0;

   frame_buffer_writer #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .HostValid(HostValid),
      .HostData (HostData),
      .HostLast (HostLast),
      .HostReady(HostReady),
      .Buf0Empty(Buf0Empty),
      .Buf1Empty(Buf1Empty),
      .WData    (WData),
      .WAddr    (WAddr),
      .WE0      (WE0),
      .WE1      (WE1),
      .Buf0Full (Buf0Full),
      .Buf1Full (Buf1Full),
      .FrameErr (FrameErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one pixel, waits (bounded) for HostReady, then checks the registered write
   task automatic send(input logic [23:0] d, input logic last, input int addr, input int sel);
      int waited = 0;
      while (!HostReady && waited < 50) begin
         step();
         waited++;
      end
      chk("ready_timeout", 32'(waited < 50), 32'd1);
      HostValid = 1'b1;
      HostData  = d;
      HostLast  = last;
      step();
      HostValid = 1'b0;
      HostLast  = 1'b0;
      chk("we0", 32'(WE0), 32'(sel == 0));
      chk("we1", 32'(WE1), 32'(sel == 1));
      chk("waddr", 32'(WAddr), 32'(addr));
      chk("wdata", WData, {8'h00, d});
   endtask

   initial begin
      reset     = 1'b1;
      HostValid = 1'b0;
      HostData  = 24'h0;
      HostLast  = 1'b0;
      Buf0Empty = 1'b0;
      Buf1Empty = 1'b0;
      step();
      chk("rst_ready", 32'(HostReady), 32'd0);
      chk("rst_wdata", WData, 32'd0);
      chk("rst_waddr", 32'(WAddr), 32'd0);
      chk("rst_we", {30'd0, WE1, WE0}, 32'd0);
      chk("rst_full", {30'd0, Buf1Full, Buf0Full}, 32'd0);
      chk("rst_ferr", 32'(FrameErr), 32'd0);
      reset = 1'b0;

      // 1: clean frame into buffer 0, pixels back to back
      step();
      chk("t1_ready", 32'(HostReady), 32'd1);
      send(24'h010203, 1'b0, 0, 0);
      send(24'h020304, 1'b0, 1, 0);
      send(24'h030405, 1'b0, 2, 0);
      send(24'h040506, 1'b1, 3, 0);
      chk("t1_full0", 32'(Buf0Full), 32'd1);
      chk("t1_ferr", 32'(FrameErr), 32'd0);
      chk("t1_ready_wait", 32'(HostReady), 32'd0);

      // 2: buffer 1, then backpressure until buffer 0 released
      send(24'h111111, 1'b0, 0, 1);
      chk("t2_we0_off", 32'(WE0), 32'd0);
      send(24'h222222, 1'b0, 1, 1);
      send(24'h333333, 1'b0, 2, 1);
      send(24'h444444, 1'b1, 3, 1);
      chk("t2_full1", 32'(Buf1Full), 32'd1);
      for (int i = 0; i < 6; i++) step();
      chk("t2_backpressure", 32'(HostReady), 32'd0);
      chk("t2_full0_held", 32'(Buf0Full), 32'd1);
      chk("t2_we_idle", {30'd0, WE1, WE0}, 32'd0);
      Buf0Empty = 1'b1;
      step();
      Buf0Empty = 1'b0;
      chk("t2_release0", 32'(Buf0Full), 32'd0);
      chk("t2_ready_lag", 32'(HostReady), 32'd0);
      step();
      chk("t2_ready_back", 32'(HostReady), 32'd1);

      // 3: early HostLast into buffer 0, then missing HostLast into buffer 1
      send(24'hA00001, 1'b0, 0, 0);
      send(24'hA00002, 1'b1, 1, 0);
      chk("t3_early_ferr", 32'(FrameErr), 32'd1);
      chk("t3_early_full0", 32'(Buf0Full), 32'd1);
      step();
      chk("t3_ferr_pulse", 32'(FrameErr), 32'd0);
      chk("t3_no_extra_we", {30'd0, WE1, WE0}, 32'd0);
      Buf1Empty = 1'b1;
      step();
      Buf1Empty = 1'b0;
      chk("t3_release1", 32'(Buf1Full), 32'd0);
      send(24'hB00001, 1'b0, 0, 1);
      send(24'hB00002, 1'b0, 1, 1);
      send(24'hB00003, 1'b0, 2, 1);
      send(24'hB00004, 1'b0, 3, 1);
      chk("t3_miss_ferr", 32'(FrameErr), 32'd1);
      chk("t3_miss_full1", 32'(Buf1Full), 32'd1);
      chk("t3_miss_ready", 32'(HostReady), 32'd0);

      // 4: gapped valid into buffer 0
      Buf0Empty = 1'b1;
      step();
      Buf0Empty = 1'b0;
      for (int i = 0; i < FW; i++) begin
         send(24'hC00000 | 24'(i), (i == FW - 1), i, 0);
         step();
         chk("t4_gap_we", {30'd0, WE1, WE0}, 32'd0);
         chk("t4_gap_addr_hold", 32'(WAddr), 32'(i));
      end
      chk("t4_full0", 32'(Buf0Full), 32'd1);
      chk("t4_ferr", 32'(FrameErr), 32'd0);

      // 5: async reset mid-frame of buffer 1
      Buf1Empty = 1'b1;
      step();
      Buf1Empty = 1'b0;
      send(24'hD00001, 1'b0, 0, 1);
      send(24'hD00002, 1'b0, 1, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_ready", 32'(HostReady), 32'd0);
      chk("t5_async_wdata", WData, 32'd0);
      chk("t5_async_waddr", 32'(WAddr), 32'd0);
      chk("t5_async_we", {30'd0, WE1, WE0}, 32'd0);
      chk("t5_async_full", {30'd0, Buf1Full, Buf0Full}, 32'd0);
      step();
      reset = 1'b0;
      send(24'hE00001, 1'b0, 0, 0);
      send(24'hE00002, 1'b0, 1, 0);
      send(24'hE00003, 1'b0, 2, 0);
      send(24'hE00004, 1'b1, 3, 0);
      chk("t5_full", {30'd0, Buf1Full, Buf0Full}, 32'd1);

      // 6: spurious Buf1Empty, then release of buffer 0 on buffer 1's final write
      Buf1Empty = 1'b1;
      step();
      step();
      chk("t6_spurious", 32'(Buf1Full), 32'd0);
      chk("t6_spurious_ready", 32'(HostReady), 32'd1);
      Buf1Empty = 1'b0;
      send(24'hF00001, 1'b0, 0, 1);
      send(24'hF00002, 1'b0, 1, 1);
      send(24'hF00003, 1'b0, 2, 1);
      Buf0Empty = 1'b1;
      send(24'hF00004, 1'b1, 3, 1);
      Buf0Empty = 1'b0;
      chk("t6_same_edge", {30'd0, Buf1Full, Buf0Full}, 32'd2);
      step();
      step();
      chk("t6_ready_buf0", 32'(HostReady), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
